fifo_write: RTL
===============

# fifo_write

Producer-side counterpart of the FIFO frame reader. On a start strobe, the block accepts exactly `data_len` bytes from an upstream byte source with a valid/ready handshake. It writes each byte into the 8-bit transfer FIFO, respecting FIFO back-pressure, then signals done and waits for the start strobe to drop. It sits between the sample packer and the transfer FIFO that the downstream reader drains.

## Interface
- No parameters; widths are fixed.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous reset, active-high.
- `err` in 1: abort request.
- `so` out 3: current state code.
- `data_len` in 12: payload byte count; latched in PRE.
- `src_data` in 8: source byte.
- `src_valid` in 1: source byte available.
- `src_ready` out 1: block accepts `src_data` this cycle.
- `fifo_txd` out 8: FIFO write data.
- `fifo_txen` out 1: FIFO write enable, one byte per high cycle.
- `fifo_full` in 1: FIFO cannot accept a write this cycle.
- `fs` in 1: frame start, level, held by the controller until `fd` is seen.
- `fd` out 1: frame done.

## Operation
- States and `so` codes:
  - IDLE=0, PRE=1, WORK=2, CSUM=3, LAST=4, ABRT=5.
  - Codes 6 and 7 go to IDLE on the next edge.
- IDLE:
  - `fs`=1 → PRE.
- PRE (1 cycle):
  - Latch `len_r`←`data_len`.
  - Clear `wr_num` and `csum_r` to 0.
  - If `data_len`==0, go to CSUM when checksum is enabled, else LAST. Otherwise go to WORK.
- WORK:
  - `src_ready` = !`fifo_full`.
  - A beat is accepted when `src_valid` & `src_ready`.
  - On a beat: `fifo_txen`=1 and `fifo_txd`=`src_data`, same cycle (combinational pass-through). Also `wr_num`+=1 and `csum_r`^=`src_data`.
  - Beat with `wr_num`==`len_r`-1 → CSUM when checksum is enabled, else LAST.
  - With no beat, stay; nothing changes.
- CSUM (checksum enabled only):
  - `fifo_txd`=`csum_r`; `fifo_txen`=!`fifo_full`.
  - Leave for LAST on the cycle the write happens.
- LAST:
  - `fd`=1; no writes.
  - `fs`=0 → IDLE.
- ABRT:
  - `err`=1 in PRE/WORK/CSUM/LAST → ABRT next edge; `err` has priority over every other transition.
  - In ABRT: `fd`=0 and no writes. Bytes already written stay in the FIFO.
  - Leave for IDLE when `fs`=0 and `err`=0.
- `src_ready`, `fifo_txen` are 0 in all states except as stated above.
- `fifo_txd`=0 when `fifo_txen`=0.
- Arithmetic:
  - `wr_num`, `len_r` are 12-bit unsigned; max payload is 4095 bytes.
  - `len_r` is frozen for the frame; `data_len` changes after PRE are ignored.
- `fs` in LAST/ABRT is level-checked only. A new frame requires `fs` to drop, return to IDLE, then rise.

## Timing
- Reset:
  - State IDLE; `len_r`, `wr_num`, `csum_r` = 0.
  - Every output is 0, including `so`.
  - Applies at the first posedge with `rst`=1, including mid-frame.
- `fs` rise → PRE on the next edge → WORK one edge later.
  - The first byte can be written 2 cycles after `fs` is sampled.
- Throughput: 1 byte/cycle when `src_valid`=1 and `fifo_full`=0.
- `fifo_full` and `src_valid` are combinational into `src_ready`/`fifo_txen`. There is no skid buffer, and no write is ever issued while `fifo_full`=1.
- `fd` rises on the edge after the last write (payload byte, or checksum byte when enabled). It falls on the edge after `fs` is sampled low.
- Simultaneous events:
  - `err`=1 together with the final beat: the beat is written, and the state goes to ABRT, not LAST.
  - `fs`=0 in WORK is ignored; the frame completes.

## Configuration
- `FIFO_WRITE_CSUM_EN` defined:
  - CSUM state is present.
  - After the payload, one extra byte equal to the XOR of all payload bytes is written (0x00 for an empty payload).
  - Frame length in the FIFO is `data_len`+1.
- Not defined:
  - CSUM state, `csum_r` and its logic are removed; code 3 is unused and maps to IDLE.
  - Frame length is `data_len`.

## Test plan
- `data_len`=4, source 0x11,0x22,0x33,0x44 always valid, `fifo_full`=0 → FIFO receives 11,22,33,44 on 4 consecutive cycles.
  - With checksum: 5th byte 0x44.
  - `fd`=1 the following edge; `fs` low → `fd`=0 and `so`=0 one edge later.
- Same frame with `fifo_full`=1 for 3 cycles mid-payload and `src_valid` toggling → `src_ready`/`fifo_txen` stay 0 during full, the byte sequence is unchanged, and no duplicate or lost bytes.
- `data_len`=0 → IDLE→PRE→LAST with zero writes (checksum off), or a single write of 0x00 (checksum on).
- `err` pulse after 2 of 8 bytes → ABRT next edge, exactly 2 bytes written, `fd` never high. After `fs`=0 and `err`=0 → IDLE; a following 8-byte frame completes normally.
- `rst` asserted in WORK after 5 of 10 bytes → all outputs 0 at that edge. After release and a new `fs`, a full 10-byte frame completes, and `wr_num` restarts at 0.
- `data_len`=4095, continuous data → exactly 4095 payload writes with no counter wrap, then `fd`.

Source files
------------

// File: rtl/fifo_write_if.sv
// Producer-side bus of fifo_write: control strobes, upstream byte source and transfer-FIFO write port.
// master = fifo_write itself, slave = the surrounding controller/source/FIFO.
interface fifo_write_if;
  logic        err;
  logic [2:0]  so;
  logic [11:0] data_len;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_ready;
  logic [7:0]  fifo_txd;
  logic        fifo_txen;
  logic        fifo_full;
  logic        fs;
  logic        fd;

  modport master (
    input  err, data_len, src_data, src_valid, fifo_full, fs,
    output so, src_ready, fifo_txd, fifo_txen, fd
  );

  modport slave (
    output err, data_len, src_data, src_valid, fifo_full, fs,
    input  so, src_ready, fifo_txd, fifo_txen, fd
  );
endinterface

// File: rtl/fifo_write.sv
// Frame writer: moves data_len source bytes into the transfer FIFO, then raises fd until fs drops.
// Define FIFO_WRITE_CSUM_EN to append an XOR checksum byte after the payload.
module fifo_write (
  input  logic         clk,
  input  logic         rst,
  fifo_write_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PRE  = 3'd1;
  localparam logic [2:0] WORK = 3'd2;
  localparam logic [2:0] LAST = 3'd4;
  localparam logic [2:0] ABRT = 3'd5;
`ifdef FIFO_WRITE_CSUM_EN
  localparam logic [2:0] CSUM = 3'd3;
  localparam logic [2:0] TAIL = CSUM;
`else
  localparam logic [2:0] TAIL = LAST;
`endif

  logic [2:0]  state, state_nxt;
  logic [11:0] len_r, wr_num;
  logic        beat;
`ifdef FIFO_WRITE_CSUM_EN
  logic [7:0]  csum_r;
`endif

  // No skid buffer: a beat only happens when the FIFO can take it this very cycle.
  assign beat   = (state == WORK) && bus.src_valid && !bus.fifo_full;
  assign bus.so = state;
  assign bus.fd = (state == LAST);

  always_comb begin
    state_nxt     = state;
    bus.src_ready = 1'b0;
    bus.fifo_txen = 1'b0;
    bus.fifo_txd  = 8'h00;
    case (state)
      IDLE: if (bus.fs) state_nxt = PRE;
      PRE: begin
        if (bus.err)                    state_nxt = ABRT;
        else if (bus.data_len == 12'd0) state_nxt = TAIL;
        else                            state_nxt = WORK;
      end
      WORK: begin
        bus.src_ready = !bus.fifo_full;
        if (beat) begin
          bus.fifo_txen = 1'b1;
          bus.fifo_txd  = bus.src_data;
        end
        if (bus.err)                                 state_nxt = ABRT;
        else if (beat && wr_num == len_r - 12'd1)    state_nxt = TAIL;
      end
`ifdef FIFO_WRITE_CSUM_EN
      CSUM: begin
        if (!bus.fifo_full) begin
          bus.fifo_txen = 1'b1;
          bus.fifo_txd  = csum_r;
        end
        if (bus.err)            state_nxt = ABRT;
        else if (!bus.fifo_full) state_nxt = LAST;
      end
`endif
      LAST: begin
        if (bus.err)     state_nxt = ABRT;
        else if (!bus.fs) state_nxt = IDLE;
      end
      ABRT: if (!bus.fs && !bus.err) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      len_r  <= 12'd0;
      wr_num <= 12'd0;
`ifdef FIFO_WRITE_CSUM_EN
      csum_r <= 8'h00;
`endif
    end else begin
      state <= state_nxt;
      if (state == PRE) begin
        len_r  <= bus.data_len;
        wr_num <= 12'd0;
`ifdef FIFO_WRITE_CSUM_EN
        csum_r <= 8'h00;
`endif
      end else if (beat) begin
        wr_num <= wr_num + 12'd1;
`ifdef FIFO_WRITE_CSUM_EN
        csum_r <= csum_r ^ bus.src_data;
`endif
      end
    end
  end
endmodule
